spi_shift_engine: RTL
=====================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame length in bits (legal 2..32).
REQ-002 SHALL have parameter CPHA, default 0: 0 = sample on SCLK rise / shift on fall; 1 = shift on rise / sample on fall.
REQ-003 SHALL have parameter LSB_FIRST, default 0: 0 = MSB transmitted and received first; 1 = LSB first.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request a frame; sampled only in IDLE.
REQ-007 SHALL have port tx_data  input  DATA_W  frame to transmit; captured when start is accepted.
REQ-008 SHALL have port sclk_in  input  1  divided serial clock from the upstream clock generator.
REQ-009 SHALL have port clk_en  output  1  enable to the clock generator; high only in XFER.
REQ-010 SHALL have port miso  input  1  serial data from the slave.
REQ-011 SHALL have port mosi  output  1  serial data to the slave.
REQ-012 SHALL have port ss_n  output  1  slave select, active-low.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-clk pulse marking frame completion.
REQ-015 SHALL have port rx_data  output  DATA_W  last received frame; held until the next done.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, XFER and HOLD.
REQ-017 SHALL register sclk_in into sclk_q every cycle and define edge strobes from them.
REQ-018 SHALL define rise = sclk_in & ~sclk_q and fall = ~sclk_in & sclk_q; both strobes are ignored outside XFER.
REQ-019 SHALL require sclk_in half-period >= 2 clk cycles (generator divisor >= 4); behaviour is undefined otherwise.
REQ-020 IDLE: on start=1, load tx_data into tx_shift, clear bit_cnt, drive ss_n=0 and busy=1, and go to SETUP on the next cycle.
REQ-021 IDLE: with start=0, SHALL stay in IDLE with ss_n=1, clk_en=0, mosi=0.
REQ-022 SETUP: SHALL last exactly 1 clk cycle and then enter XFER with clk_en=1.
REQ-023 SETUP, CPHA=0: mosi SHALL carry the first bit of tx_shift.
REQ-024 XFER, CPHA=0: on rise, sample miso into rx_shift and increment bit_cnt.
REQ-025 XFER, CPHA=0: on fall, advance mosi to the next bit.
REQ-026 XFER, CPHA=0: on the fall following the DATA_W-th sample, drop clk_en and go to HOLD.
REQ-027 XFER, CPHA=1: on rise, drive the next bit on mosi.
REQ-028 XFER, CPHA=1: on fall, sample miso and increment bit_cnt.
REQ-029 XFER, CPHA=1: on the DATA_W-th sample, drop clk_en and go to HOLD.
REQ-030 The transfer SHALL contain exactly DATA_W rises and DATA_W falls, so SCLK ends low.
REQ-031 bit_cnt SHALL be $clog2(DATA_W+1) bits wide and never wrap within a frame.
REQ-032 Shift direction SHALL follow LSB_FIRST, applying identically to tx and rx.
REQ-033 HOLD: SHALL last 1 clk cycle, then set ss_n=1 and rx_data=rx_shift, pulse done for 1 cycle, and go to IDLE.
REQ-034 start SHALL be ignored in SETUP, XFER and HOLD; a new start is accepted in the first IDLE cycle, i.e. the done cycle.
REQ-035 tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-036 mosi SHALL change only on clk edges and never glitch.

Reset
REQ-037 rst=1 at a clk edge SHALL force IDLE, ss_n=1, clk_en=0, mosi=0, busy=0, done=0, rx_data=0, bit_cnt=0, sclk_q=0.
REQ-038 Reset mid-frame SHALL abort without asserting done and without updating rx_data; the next start begins a fresh frame.
REQ-039 rst SHALL take priority over start and over edge strobes in the same cycle.

Verification
REQ-040 CPHA=0, MSB-first, divisor 4, miso looped to mosi, tx_data=0xA5 -> 8 rises on sclk_in, done pulses once, rx_data=0xA5, and ss_n is low from the cycle after start through HOLD.
REQ-041 CPHA=1, miso tied 1, tx_data=0x3C -> mosi bit sequence 0,0,1,1,1,1,0,0 on successive rises, rx_data=0xFF, single done pulse.
REQ-042 LSB_FIRST=1, tx_data=0x01, loopback -> first mosi bit =1, rx_data=0x01.
REQ-043 start re-pulsed with tx_data=0xFF during XFER of 0x12 -> frame transmits 0x12 only, exactly one done.
REQ-044 rst asserted after 3 sampled bits -> next cycle ss_n=1, clk_en=0, busy=0, rx_data=0x00, no done; a subsequent start with 0x5A completes with rx_data=0x5A under loopback.
REQ-045 start held high continuously, two frames 0x81 then 0x7E -> second frame accepted on the done cycle, back-to-back, with ss_n high for exactly 1 cycle between frames.

Source files
------------

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: frames DATA_W bits against an external SCLK.
// Edges of sclk_in are detected in the clk domain and only act in XFER.
module spi_shift_engine #(
  parameter int DATA_W    = 8,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              sclk_in,
  output logic              clk_en,
  input  logic              miso,
  output logic              mosi,
  output logic              ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic              sclk_q;
  logic              rise, fall;
  logic              smp, shf;
  logic              last;
  logic [DATA_W-1:0] tx_shift, tx_nx;
  logic [DATA_W-1:0] rx_shift, rx_nx;
  logic [DATA_W-1:0] rx_q, rxd_nx;
  logic [CNT_W-1:0]  bit_cnt, cnt_nx;
  logic              mosi_q, mosi_nx;
  logic              ss_n_q, ss_nx;
  logic              done_q, done_nx;

  function automatic logic head(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shin(
    input logic [DATA_W-1:0] v,
    input logic              b
  );
    return (LSB_FIRST != 0) ? {b, v[DATA_W-1:1]}
                            : {v[DATA_W-2:0], b};
  endfunction

  assign rise = sclk_in & ~sclk_q & (state == XFER);
  assign fall = ~sclk_in & sclk_q & (state == XFER);
  assign smp  = (CPHA == 0) ? rise : fall;
  assign shf  = (CPHA == 0) ? fall : rise;
  assign last = (bit_cnt == CNT_W'(DATA_W));

  always_comb begin
    state_nx = state;
    tx_nx    = tx_shift;
    rx_nx    = rx_shift;
    rxd_nx   = rx_q;
    cnt_nx   = bit_cnt;
    mosi_nx  = mosi_q;
    ss_nx    = ss_n_q;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        mosi_nx = 1'b0;
        ss_nx   = 1'b1;
        if (start) begin
          state_nx = SETUP;
          cnt_nx   = '0;
          rx_nx    = '0;
          ss_nx    = 1'b0;
          // CPHA=0 presents the first bit before the first edge
          if (CPHA == 0) begin
            mosi_nx = head(tx_data);
            tx_nx   = adv(tx_data);
          end else begin
            tx_nx = tx_data;
          end
        end
      end
      SETUP: state_nx = XFER;
      XFER: begin
        if (CPHA == 0) begin
          if (smp && !last) begin
            rx_nx  = shin(rx_shift, miso);
            cnt_nx = bit_cnt + 1'b1;
          end
          if (shf) begin
            if (last) begin
              state_nx = HOLD;
            end else begin
              mosi_nx = head(tx_shift);
              tx_nx   = adv(tx_shift);
            end
          end
        end else begin
          if (shf) begin
            mosi_nx = head(tx_shift);
            tx_nx   = adv(tx_shift);
          end
          if (smp) begin
            rx_nx  = shin(rx_shift, miso);
            cnt_nx = bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1))
              state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        state_nx = IDLE;
        ss_nx    = 1'b1;
        mosi_nx  = 1'b0;
        done_nx  = 1'b1;
        rxd_nx   = rx_shift;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sclk_q   <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_q     <= '0;
      bit_cnt  <= '0;
      mosi_q   <= 1'b0;
      ss_n_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      sclk_q   <= sclk_in;
      tx_shift <= tx_nx;
      rx_shift <= rx_nx;
      rx_q     <= rxd_nx;
      bit_cnt  <= cnt_nx;
      mosi_q   <= mosi_nx;
      ss_n_q   <= ss_nx;
      done_q   <= done_nx;
    end
  end

  assign clk_en  = (state == XFER);
  assign busy    = (state != IDLE);
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule
